// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and frame constants.
// Imported by the loader top and its word assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int HDR_LEN = 3;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a stream of bytes into little-endian 32-bit words.
// o_word_vld is high in the cycle the fourth byte is taken.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_sr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= {i_byte, r_sr[23:8]};
    end
  end

  // Earlier bytes sit low, so the live byte completes bits [31:24].
  assign o_word     = {i_byte, r_sr};
  assign o_word_vld = i_en && (r_cnt == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream into imem words, CPU held
// in reset until a frame with a matching checksum is loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter int         MAX_WORDS = 4096,
  parameter logic [7:0] MAGIC     = MAGIC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_address,
  output logic [31:0]       imem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CW = ADDR_W + 1;

  state_t r_state;
  state_t w_next;

  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [CW-1:0]     r_wcnt;
  logic [7:0]        r_csum;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  logic        w_acc;
  logic        w_start;
  logic        w_in_data;
  logic        w_word_vld;
  logic        w_last;
  logic [31:0] w_word;
  logic [15:0] w_len;

  assign rx_ready  = (r_state != ST_DONE);
  assign w_acc     = rx_valid && rx_ready;
  assign w_start   = w_acc && (rx_data == MAGIC) &&
                     ((r_state == ST_IDLE) ||
                      (r_state == ST_ERROR));
  assign w_in_data = w_acc && (r_state == ST_DATA);
  assign w_len     = {rx_data, r_len_lo};
  assign w_last    = (32'(r_wcnt) + 32'd1) == 32'(r_len);

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .i_en       (w_in_data),
    .i_clr      (w_start),
    .i_byte     (rx_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (w_start) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_acc) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_acc) begin
          if (w_len == 16'd0)
            w_next = ST_CHECK;
          else if (32'(w_len) > 32'(MAX_WORDS))
            w_next = ST_ERROR;
          else
            w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_vld && w_last) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_acc)
          w_next = (rx_data == r_csum) ? ST_DONE : ST_ERROR;
      end
      ST_DONE: begin
        w_next = ST_DONE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len_lo <= '0;
      r_len    <= '0;
    end else if (w_acc) begin
      if (r_state == ST_LEN_LO) r_len_lo <= rx_data;
      if (r_state == ST_LEN_HI) r_len    <= w_len;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_csum <= '0;
      r_wcnt <= '0;
    end else if (w_start) begin
      r_csum <= '0;
      r_wcnt <= '0;
    end else if (w_in_data) begin
      r_csum <= r_csum ^ rx_data;
      if (w_word_vld) r_wcnt <= r_wcnt + CW'(1);
    end
  end

  // Address and data are registered with the strobe so they
  // are stable for the whole write cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wren <= w_word_vld;
      if (w_word_vld) begin
        r_addr <= r_wcnt[ADDR_W-1:0];
        r_data <= w_word;
      end
    end
  end

  assign imem_wren    = r_wren;
  assign imem_address = r_addr;
  assign imem_data    = r_data;
  assign cpu_hold     = (r_state != ST_DONE);
  assign done         = (r_state == ST_DONE);
  assign error        = (r_state == ST_ERROR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: it receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes those words into imem at consecutive word addresses starting from 0, and holds the processor in reset until a frame with a valid checksum has been loaded. It sits beside the processor on the imem address/data lines and drives the imem write port. The processor is the reader on that port; this block is the writer.

## Interface
Parameters:
- ADDR_W, 12, imem word-address width
- MAX_WORDS, 4096, largest accepted word count (must be ≤ 2^ADDR_W)
- MAGIC, 8'hA5, frame start byte

Ports:
- clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- rx_valid  in  1  byte offered on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader can accept a byte
- imem_wren  out  1  single-cycle imem write strobe
- imem_address  out  ADDR_W  word address for the write
- imem_data  out  32  word to write
- cpu_hold  out  1  held high to keep the processor in reset
- done  out  1  load completed and checksum matched (sticky)
- error  out  1  frame rejected (sticky until the next MAGIC)

## Operation
- Frame format: MAGIC, LEN_LO, LEN_HI, then 4×LEN payload bytes, then CSUM.
  - LEN is a 16-bit word count.
  - Payload words are little-endian: the first byte goes to bits [7:0].
  - CSUM is the XOR of all payload bytes.
- A byte transfers when rx_valid && rx_ready are both high on a rising clock edge.
- State machine states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE → LEN_LO on MAGIC. Any other byte is accepted and discarded.
- LEN_LO → LEN_HI: latch the low length byte.
- LEN_HI → DATA when 0 < LEN ≤ MAX_WORDS.
- LEN_HI → CHECK when LEN == 0.
- LEN_HI → ERROR when LEN > MAX_WORDS.
- DATA: a 2-bit byte counter fills a 32-bit shift register and each byte is XORed into the running checksum.
  - On the 4th byte, the assembled word is registered to imem_data, imem_address takes the current word counter, and imem_wren pulses.
  - The word counter then increments.
  - After word LEN−1 the state moves to CHECK.
- CHECK: one byte is accepted. A match goes to DONE; a mismatch goes to ERROR.
- DONE: rx_ready=0, cpu_hold=0, done=1. This state is exited only by reset.
- ERROR: rx_ready=1, cpu_hold=1, error=1.
  - MAGIC clears error, resets the checksum and counters, and goes to LEN_LO.
  - Other bytes are discarded.
- Imem contents written before an error are left in place and are not erased.
- Width rules:
  - The word counter is ADDR_W+1 bits wide so it can reach MAX_WORDS without wrap.
  - imem_address is the low ADDR_W bits of the counter.

## Timing
- Reset values:
  - state=IDLE.
  - rx_ready=1, cpu_hold=1.
  - imem_wren=0, imem_address=0, imem_data=0.
  - done=0, error=0.
  - Checksum and all counters 0.
- rx_ready is combinational from state: high in every state except DONE. The loader never stalls mid-frame.
- Write latency: imem_wren is high in the cycle after the 4th byte of a word is accepted. It is high for exactly one cycle, and imem_address and imem_data are stable during that cycle.
- Back-to-back bytes every cycle are supported. The next word's first byte can be accepted in the same cycle as the previous word's imem_wren.
- cpu_hold falls in the cycle after the matching CSUM byte is accepted, the same edge at which done rises.
- When LEN=MAX_WORDS, the last write goes to address MAX_WORDS−1 and the counter reaches MAX_WORDS without reaching the write path.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). Any in-flight imem_wren is dropped.

## Structure
- The shared package holds:
  - the state enum (IDLE..ERROR);
  - the MAGIC default;
  - the frame field constants (header length 3, bytes per word 4).
- One natural sub-module is `word_assembler`: byte counter, shift register and word-complete strobe, with its own async active-low reset.
- The FSM, checksum and word counter stay in imem_loader.

## Test plan
- Frame A5 02 00, payload 11 22 33 44 55 66 77 88, CSUM 88 → writes 0x44332211 @0 and 0x88776655 @1. done=1, cpu_hold drops one cycle after CSUM.
- Same frame with CSUM 00 → error=1, cpu_hold stays 1. A following correct frame then completes with done=1.
- LEN=0: A5 00 00 00 → no imem_wren, done=1.
- LEN=0x1001 (> 4096) → error=1 immediately after LEN_HI; no writes occur.
- Garbage bytes 00 FF 3C before A5, with rx_valid toggling randomly during the frame → garbage is ignored and writes are identical to the first scenario.
- Assert reset low after 5 payload bytes → one write only, outputs return to reset values, and a restarted frame loads correctly from address 0.
